fifo_rd_stream: RTL and testbench

//   Read-side consumer for the dual-clock FIFO. Lives in the rclk domain.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_obuf.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 77 +++++++
 tb/tb_fifo_rd_stream.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the dual-clock FIFO read side.
package fifo_pkg;

  localparam int unsigned FIFO_WSIZE = 8;

  // Bits needed to hold values 0..max_val (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat == 0) || (lat == 1);
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Circular output buffer with registered head word; pointers wrap at DEPTH,
// which need not be a power of two.
module fifo_rd_obuf
  import fifo_pkg::*;
#(
  parameter int unsigned WSIZE = FIFO_WSIZE,
  parameter int unsigned DEPTH = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic [WSIZE-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WSIZE-1:0]            o_data,
  output logic                        o_valid,
  output logic [cnt_width(DEPTH)-1:0] o_occ
);

  localparam int unsigned OW = cnt_width(DEPTH);
  localparam int unsigned PW = cnt_width(DEPTH - 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [WSIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [OW-1:0]    r_occ;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_occ != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      assert (!(i_push && (r_occ == FULL)))
        else $error("fifo_rd_obuf: capture into a full buffer");
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
      end
      if (w_do_pop) r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
      case ({i_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port consumer: credit-tracked pops into an output buffer that
// drives a valid/ready stream, plus a delivered-word counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WSIZE      = FIFO_WSIZE,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned OBUF_DEPTH = 3
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [WSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [WSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [15:0]      rd_count
);

  localparam int unsigned OW = cnt_width(OBUF_DEPTH);
  localparam logic [OW:0] DEPTH_V = (OW + 1)'(OBUF_DEPTH);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("fifo_rd_stream: RD_LATENCY must be 0 or 1");
  end
  if ((OBUF_DEPTH < 2) || (OBUF_DEPTH > 8)) begin : g_bad_depth
    $error("fifo_rd_stream: OBUF_DEPTH must be in 2..8");
  end

  logic [OW-1:0] w_occ;
  logic [OW:0]   w_committed;
  logic          w_inflight;
  logic          w_push;
  logic          w_xfer;
  logic [15:0]   r_rd_count;

  if (RD_LATENCY == 0) begin : g_lat0
    assign w_inflight = 1'b0;
    assign w_push     = rinc;
  end else begin : g_lat1
    logic r_inflight;
    always_ff @(posedge rclk) begin
      if (rrst) r_inflight <= 1'b0;
      else      r_inflight <= rinc;
    end
    assign w_inflight = r_inflight;
    assign w_push     = r_inflight;
  end

  // Credits count buffered plus in-flight words; m_ready stays off this path.
  assign w_committed = {1'b0, w_occ} + {{OW{1'b0}}, w_inflight};
  assign rinc        = !rrst && !rempty && (w_committed < DEPTH_V);
  assign w_xfer      = m_valid && m_ready;

  fifo_rd_obuf #(
    .WSIZE (WSIZE),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .i_clk   (rclk),
    .i_rst   (rrst),
    .i_push  (w_push),
    .i_data  (rdata),
    .i_pop   (w_xfer),
    .o_data  (m_data),
    .o_valid (m_valid),
    .o_occ   (w_occ)
  );

  always_ff @(posedge rclk) begin
    if (rrst)        r_rd_count <= '0;
    else if (w_xfer) r_rd_count <= r_rd_count + 16'd1;
  end

  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: two configurations (latency 1 / depth 3, latency 0 / depth 2)
// fed by behavioural FIFO read-port models sharing one clock and stimulus.
module tb_fifo_rd_stream;

  localparam int unsigned NDUT  = 2;
  localparam int unsigned MEMSZ = 1 << 17;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 0;
  endfunction
  function automatic int depth_of(input int g);
    return (g == 0) ? 3 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rrst = 1'b1;
  logic        m_ready = 1'b0;
  logic        force_empty = 1'b1;
  logic        rempty   [NDUT] = '{default: 1'b1};
  logic [7:0]  rdata    [NDUT] = '{default: 8'h00};
  logic        rinc     [NDUT];
  logic        m_valid  [NDUT];
  logic [7:0]  m_data   [NDUT];
  logic [15:0] rd_count [NDUT];

  logic [7:0]  src_mem [NDUT][MEMSZ];
  logic [7:0]  exp_mem [NDUT][MEMSZ];
  int unsigned src_wr  [NDUT] = '{default: 0};
  int unsigned src_rd  [NDUT] = '{default: 0};
  int unsigned exp_wr  [NDUT] = '{default: 0};
  int unsigned exp_rd  [NDUT] = '{default: 0};
  int unsigned pop_cnt [NDUT] = '{default: 0};
  int unsigned xfer_cnt[NDUT] = '{default: 0};
  int first_rinc [NDUT] = '{default: -1};
  int first_valid[NDUT] = '{default: -1};
  int first_xfer [NDUT] = '{default: -1};
  int last_xfer  [NDUT] = '{default: -1};
  int cyc  = 0;
  int mark = 0;
  int checks = 0;
  int errors = 0;

  fifo_rd_stream #(.WSIZE(8), .RD_LATENCY(1), .OBUF_DEPTH(3)) u_dut_l1 (
    .rclk(clk), .rrst(rrst), .rempty(rempty[0]), .rdata(rdata[0]), .rinc(rinc[0]),
    .m_valid(m_valid[0]), .m_data(m_data[0]), .m_ready(m_ready), .rd_count(rd_count[0]));

  fifo_rd_stream #(.WSIZE(8), .RD_LATENCY(0), .OBUF_DEPTH(2)) u_dut_l0 (
    .rclk(clk), .rrst(rrst), .rempty(rempty[1]), .rdata(rdata[1]), .rinc(rinc[1]),
    .m_valid(m_valid[1]), .m_data(m_data[1]), .m_ready(m_ready), .rd_count(rd_count[1]));

  task automatic chk(input bit ok, input string name, input int g, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h (cycle %0d)", name, g, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  for (genvar g = 0; g < NDUT; g++) begin : g_bfm
    localparam int LATG = (g == 0) ? 1 : 0;
    bit         pop_n = 1'b0;
    bit         popped;
    logic [7:0] last_pop;
    bit         prev_v = 1'b0;
    bit         prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int         seen_mark = -1;

    // FIFO read port: pop decided from rinc sampled mid-cycle, outputs move 2 units after the edge.
    always @(posedge clk) begin
      popped = 1'b0;
      if (pop_n) begin
        if (src_rd[g] == src_wr[g]) begin
          chk(1'b0, "pop_underflow", g, src_rd[g], src_wr[g]);
        end else begin
          last_pop = src_mem[g][src_rd[g]];
          src_rd[g]++;
          exp_mem[g][exp_wr[g]] = last_pop;
          exp_wr[g]++;
          pop_cnt[g]++;
          popped = 1'b1;
        end
      end
      #2;
      rempty[g] = force_empty || (src_rd[g] == src_wr[g]);
      if (LATG == 0)
        rdata[g] = (src_rd[g] != src_wr[g]) ? src_mem[g][src_rd[g]] : 8'($urandom);
      else if (popped)
        rdata[g] = last_pop;
    end

    always @(negedge clk) begin
      pop_n = rinc[g];
      if (seen_mark != mark) begin
        seen_mark      = mark;
        first_rinc[g]  = -1;
        first_valid[g] = -1;
        first_xfer[g]  = -1;
        last_xfer[g]   = -1;
      end
      if (rrst) begin
        exp_rd[g]   = exp_wr[g];
        xfer_cnt[g] = 0;
        prev_v      = 1'b0;
      end else begin
        if (rempty[g]) chk(!rinc[g], "rinc_while_empty", g, rinc[g], 0);
        chk(rd_count[g] == 16'(xfer_cnt[g]), "rd_count_track", g, rd_count[g], 16'(xfer_cnt[g]));
        if (prev_v && !prev_r)
          chk(m_valid[g] && (m_data[g] == prev_d), "hold_stable", g, {m_valid[g], m_data[g]}, {1'b1, prev_d});
        if (rinc[g] && first_rinc[g] < 0) first_rinc[g] = cyc;
        if (m_valid[g] && first_valid[g] < 0) first_valid[g] = cyc;
        if (m_valid[g] && m_ready) begin
          chk(exp_rd[g] != exp_wr[g], "word_expected", g, exp_wr[g] - exp_rd[g], 1);
          if (exp_rd[g] != exp_wr[g]) begin
            chk(m_data[g] == exp_mem[g][exp_rd[g]], "order", g, m_data[g], exp_mem[g][exp_rd[g]]);
            exp_rd[g]++;
          end
          if (first_xfer[g] < 0) first_xfer[g] = cyc;
          last_xfer[g] = cyc;
          xfer_cnt[g]++;
        end
        prev_v = m_valid[g];
        prev_r = m_ready;
        prev_d = m_data[g];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [7:0] v);
    for (int g = 0; g < NDUT; g++) begin
      src_mem[g][src_wr[g]] = v;
      src_wr[g]++;
    end
  endtask

  function automatic bit drained();
    for (int g = 0; g < NDUT; g++)
      if ((src_rd[g] != src_wr[g]) || (exp_rd[g] != exp_wr[g])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!drained() && n < budget) begin
      step(1);
      n++;
    end
    chk(drained(), "drain_timeout", 0, n, budget);
  endtask

  task automatic do_reset();
    step(1);
    rrst = 1'b1;
    step(2);
    rrst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base [NDUT];
    int unsigned rem  [NDUT];
    int n;

    // Idle with an empty FIFO
    step(3);
    rrst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        chk(!rinc[g], "idle_rinc", g, rinc[g], 0);
        chk(!m_valid[g], "idle_valid", g, m_valid[g], 0);
        chk(rd_count[g] == 16'h0000, "idle_count", g, rd_count[g], 0);
      end
    end

    // Preloaded 0..7, always ready: latency and full throughput
    do_reset();
    mark++;
    m_ready = 1'b1;
    force_empty = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    wait_drain(200);
    step(2);
    for (int g = 0; g < NDUT; g++) begin
      chk(first_valid[g] - first_rinc[g] == lat_of(g) + 1, "rinc_to_valid", g,
          first_valid[g] - first_rinc[g], lat_of(g) + 1);
      chk(last_xfer[g] - first_xfer[g] == 7, "throughput", g, last_xfer[g] - first_xfer[g], 7);
      chk(rd_count[g] == 16'd8, "count_8", g, rd_count[g], 8);
    end

    // Back-pressure: pops stop at buffer depth, head held, then release
    do_reset();
    m_ready = 1'b0;
    for (int g = 0; g < NDUT; g++) base[g] = pop_cnt[g];
    for (int i = 0; i < 8; i++) push_word(8'(i));
    step(20);
    for (int g = 0; g < NDUT; g++) begin
      chk(pop_cnt[g] - base[g] == depth_of(g), "bp_pops", g, pop_cnt[g] - base[g], depth_of(g));
      chk(m_valid[g] && (m_data[g] == 8'h00), "bp_head", g, {m_valid[g], m_data[g]}, 9'h100);
    end
    mark++;
    m_ready = 1'b1;
    wait_drain(200);
    step(2);
    for (int g = 0; g < NDUT; g++) begin
      chk(last_xfer[g] - first_xfer[g] == 7, "release_nogap", g, last_xfer[g] - first_xfer[g], 7);
      chk(rd_count[g] == 16'd8, "release_count", g, rd_count[g], 8);
    end

    // Random ready and random empty over 1000 words
    do_reset();
    for (int i = 0; i < 1000; i++) push_word(8'($urandom));
    n = 0;
    while (!drained() && n < 20000) begin
      m_ready     = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 3) == 0);
      step(1);
      n++;
    end
    chk(drained(), "random_drain", 0, n, 20000);
    force_empty = 1'b0;
    m_ready = 1'b1;
    step(2);
    for (int g = 0; g < NDUT; g++)
      chk(rd_count[g] == 16'd1000, "random_count", g, rd_count[g], 1000);

    // Reset with words buffered and one in flight
    do_reset();
    m_ready = 1'b0;
    base[0] = pop_cnt[0];
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
    n = 0;
    while (pop_cnt[0] != base[0] + 3 && n < 20) begin
      step(1);
      n++;
    end
    chk(pop_cnt[0] == base[0] + 3, "rst_setup", 0, pop_cnt[0] - base[0], 3);
    rrst = 1'b1;
    for (int g = 0; g < NDUT; g++) rem[g] = src_wr[g] - src_rd[g];
    step(1);
    for (int g = 0; g < NDUT; g++) begin
      chk(!m_valid[g], "rst_valid", g, m_valid[g], 0);
      chk(rd_count[g] == 16'h0000, "rst_count", g, rd_count[g], 0);
      chk(!rinc[g], "rst_rinc", g, rinc[g], 0);
    end
    step(1);
    rrst = 1'b0;
    mark++;
    m_ready = 1'b1;
    wait_drain(200);
    step(2);
    for (int g = 0; g < NDUT; g++)
      chk(rd_count[g] == 16'(rem[g]), "rst_resume", g, rd_count[g], rem[g]);

    // Long run to wrap the delivered-word counter
    do_reset();
    for (int i = 0; i < 65534; i++) push_word(8'($urandom));
    wait_drain(70000);
    step(2);
    for (int g = 0; g < NDUT; g++)
      chk(rd_count[g] == 16'hFFFE, "count_fffe", g, rd_count[g], 16'hFFFE);
    push_word(8'hA5);
    wait_drain(50);
    step(2);
    for (int g = 0; g < NDUT; g++)
      chk(rd_count[g] == 16'hFFFF, "count_ffff", g, rd_count[g], 16'hFFFF);
    push_word(8'h5A);
    wait_drain(50);
    step(2);
    for (int g = 0; g < NDUT; g++)
      chk(rd_count[g] == 16'h0000, "count_wrap", g, rd_count[g], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
